serial_monitor: RTL and testbench
=================================

Name: serial_monitor

Overview:
- Parametrised successor to the top-level UART load/dump/exec monitor, packaged as a standalone block.
- Sits between the UART byte interface, the dual-port RAM and the CPU. Owns RAM/UART while monitor_control=1; the top level muxes on that output.
- Adds over the previous generation: ADDR_WIDTH-generic addressing, 16-bit lengths, checksum command, load checksum reply, unknown-command reply, inter-byte timeout, halt notification byte, configurable echo.

Parameters:
- ADDR_WIDTH, 12, RAM address width (1..16).
- TIMEOUT_CYCLES, 24000000, idle cycles between bytes of a frame before abort (0 disables).
- ECHO, 1, echo header bytes and load data bytes when 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_byte  in  8  UART received byte
- received  in  1  one-cycle strobe, rx_byte valid
- is_transmitting  in  1  UART busy
- tx_byte  out  8  byte to send
- transmit  out  1  one-cycle send strobe
- raddr  out  ADDR_WIDTH  RAM read address (1-cycle synchronous read)
- dout  in  8  RAM read data
- waddr  out  ADDR_WIDTH  RAM write address
- din  out  8  RAM write data
- write_en  out  1  RAM write strobe
- cpu_reset  out  1  CPU reset pulse
- startaddr  out  ADDR_WIDTH  CPU start address
- halted  in  1  CPU halted
- monitor_control  out  1  1 = monitor owns RAM/UART
- state_out  out  4  current FSM state, for LEDs
- timeout_err  out  1  sticky; set on timeout abort, cleared by next valid command byte

Behaviour:
- Reset (async, rst=1): state IDLE; monitor_control=1; all other outputs 0; internal addr/len/sum cleared.
- Frame format: cmd, addr_hi, addr_lo, len_hi, len_lo. Address is 16-bit; the low ADDR_WIDTH bits are used. Commands:
  - 0x4C 'L' load
  - 0x44 'D' dump
  - 0x43 'C' checksum
  - 0x58 'X' exec (address used as startaddr; len ignored but still received)
- Echo (ECHO=1): each header byte and each load byte is echoed with transmit=1 in the cycle after received. The host paces at UART rate, so the UART is always idle then.
- Unknown cmd byte: transmit 0x3F and stay in IDLE.
- States:
  - IDLE: waits for the cmd byte.
  - HDR: 2-bit byte counter, four more bytes.
  - DISPATCH: one cycle.
  - LOAD_WAIT / LOAD_WR.
  - DUMP_RD / DUMP_LAT / DUMP_TX.
  - SUM_RD / SUM_LAT / SUM_ACC.
  - TX_RESULT.
  - EXEC_RST / RUN.
- Load: for each received byte, waddr=addr, din=byte, write_en=1 for exactly one cycle; sum+=byte (mod 256); addr+=1; len-=1. When len reaches 0, go to TX_RESULT and send sum once !is_transmitting. len=0 sends 0x00 immediately.
- Dump: per byte:
  - raddr=addr; wait one cycle for dout.
  - Wait for !is_transmitting, then tx_byte=dout, transmit=1.
  - Skip one cycle before re-sampling is_transmitting (the UART asserts busy one cycle late).
  - len=0 sends nothing; return to IDLE.
- Checksum: reads len bytes at one byte per 2 cycles, 8-bit wrapping sum, then sends one byte via TX_RESULT. len=0 sends 0x00.
- Address wraps modulo 2^ADDR_WIDTH on increment. len is 16-bit, so max 65535 bytes.
- Exec: startaddr=addr; cpu_reset=1 for exactly 2 cycles (EXEC_RST, then first RUN cycle); monitor_control=0 from the EXEC_RST cycle onward.
- RUN: halted is ignored during the 2 reset cycles. On halted=1 afterwards: monitor_control=1, then when !is_transmitting send 0x48, go to IDLE.
- halted while monitor_control=1 is ignored.
- Timeout: a counter reloads on every received strobe and counts only in HDR and LOAD_WAIT. On reaching TIMEOUT_CYCLES: go to IDLE, set timeout_err, no transmit, no write.
- Outside HDR/LOAD_WAIT/IDLE, received bytes are discarded.
- Strobes (transmit, write_en, cpu_reset) default to 0 every cycle unless asserted by the current state.
- Simultaneous received and timeout expiry in the same cycle: received wins.

Test Plan:
- Send 4C 00 10 00 03, then AA 55 01 → five header echoes plus three data echoes; RAM[0x010..0x012]=AA,55,01; reply 0x00 ((AA+55+01) mod 256); write_en exactly 3 single-cycle pulses.
- After the load, send 44 00 10 00 03 → header echo, then AA 55 01 with no transmit asserted while is_transmitting=1; send 43 00 10 00 03 → reply 0x00.
- ADDR_WIDTH=12, load 4C 0F FF 00 02 with 11 22 → RAM[0xFFF]=11, RAM[0x000]=22 (wrap); dump confirms.
- Send 58 01 00 00 00 → startaddr=0x100, cpu_reset high 2 cycles, monitor_control=0; raise halted after 50 cycles → monitor_control=1, tx 0x48.
- TIMEOUT_CYCLES=100: send 4C 00 then silence → IDLE after 100 cycles, timeout_err=1, no write; next byte 44 clears timeout_err.
- Send 7E → tx 0x3F, state IDLE. Assert rst mid-dump → all outputs 0, monitor_control=1, no further transmit.

Source files
------------

// File: rtl/serial_monitor.sv
// serial_monitor: UART load/dump/checksum/exec monitor sitting between the
// UART byte interface, a dual-port RAM and the CPU. Owns RAM and UART while
// monitor_control=1; the top level muxes on that output.
module serial_monitor #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 24000000,
  parameter bit ECHO           = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_byte,
  input  logic                  received,
  input  logic                  is_transmitting,
  output logic [7:0]            tx_byte,
  output logic                  transmit,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [7:0]            dout,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [7:0]            din,
  output logic                  write_en,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] startaddr,
  input  logic                  halted,
  output logic                  monitor_control,
  output logic [3:0]            state_out,
  output logic                  timeout_err
);

  localparam logic [7:0] CMD_LOAD      = 8'h4C;
  localparam logic [7:0] CMD_DUMP      = 8'h44;
  localparam logic [7:0] CMD_SUM       = 8'h43;
  localparam logic [7:0] CMD_EXEC      = 8'h58;
  localparam logic [7:0] REPLY_UNKNOWN = 8'h3F;
  localparam logic [7:0] REPLY_HALT    = 8'h48;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HDR       = 4'd1,
    DISPATCH  = 4'd2,
    LOAD_WAIT = 4'd3,
    LOAD_WR   = 4'd4,
    DUMP_RD   = 4'd5,
    DUMP_LAT  = 4'd6,
    DUMP_TX   = 4'd7,
    SUM_RD    = 4'd8,
    SUM_LAT   = 4'd9,
    SUM_ACC   = 4'd10,
    TX_RESULT = 4'd11,
    EXEC_RST  = 4'd12,
    RUN       = 4'd13
  } state_t;

  state_t                state;
  logic [7:0]            cmd;
  logic [7:0]            addr_hi;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           len;
  logic [7:0]            sum;
  logic [1:0]            hdr_cnt;
  logic                  run_armed;
  logic [TW-1:0]         tmo_cnt;
  logic                  cmd_known;
  logic                  tmo_active;
  logic                  tmo_hit;

  assign state_out  = state;
  assign cmd_known  = (rx_byte == CMD_LOAD) || (rx_byte == CMD_DUMP) ||
                      (rx_byte == CMD_SUM)  || (rx_byte == CMD_EXEC);
  assign tmo_active = (TIMEOUT_CYCLES != 0) && ((state == HDR) || (state == LOAD_WAIT));
  // A strobe in the expiry cycle takes priority over the abort.
  assign tmo_hit    = tmo_active && !received && (tmo_cnt == TMO_LAST);

  // Inter-byte idle counter: cleared by every received strobe, runs only mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (received || !tmo_active) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Monitor FSM; all outputs registered, strobes default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cmd             <= '0;
      addr_hi         <= '0;
      addr            <= '0;
      len             <= '0;
      sum             <= '0;
      hdr_cnt         <= '0;
      run_armed       <= 1'b0;
      tx_byte         <= '0;
      transmit        <= 1'b0;
      raddr           <= '0;
      waddr           <= '0;
      din             <= '0;
      write_en        <= 1'b0;
      cpu_reset       <= 1'b0;
      startaddr       <= '0;
      monitor_control <= 1'b1;
      timeout_err     <= 1'b0;
    end else begin
      transmit  <= 1'b0;
      write_en  <= 1'b0;
      cpu_reset <= 1'b0;
      unique case (state)
        IDLE: begin
          if (received) begin
            if (cmd_known) begin
              cmd         <= rx_byte;
              sum         <= '0;
              hdr_cnt     <= '0;
              timeout_err <= 1'b0;
              state       <= HDR;
              if (ECHO) begin
                tx_byte  <= rx_byte;
                transmit <= 1'b1;
              end
            end else begin
              tx_byte  <= REPLY_UNKNOWN;
              transmit <= 1'b1;
            end
          end
        end
        HDR: begin
          if (received) begin
            if (ECHO) begin
              tx_byte  <= rx_byte;
              transmit <= 1'b1;
            end
            hdr_cnt <= hdr_cnt + 2'd1;
            unique case (hdr_cnt)
              2'd0: addr_hi <= rx_byte;
              2'd1: addr <= ADDR_WIDTH'({addr_hi, rx_byte});
              2'd2: len[15:8] <= rx_byte;
              default: begin
                len[7:0] <= rx_byte;
                state    <= DISPATCH;
              end
            endcase
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        DISPATCH: begin
          case (cmd)
            CMD_LOAD: state <= (len == 16'd0) ? TX_RESULT : LOAD_WAIT;
            CMD_DUMP: state <= (len == 16'd0) ? IDLE : DUMP_RD;
            CMD_SUM:  state <= (len == 16'd0) ? TX_RESULT : SUM_RD;
            default: begin
              startaddr       <= addr;
              cpu_reset       <= 1'b1;
              monitor_control <= 1'b0;
              state           <= EXEC_RST;
            end
          endcase
        end
        LOAD_WAIT: begin
          if (received) begin
            waddr    <= addr;
            din      <= rx_byte;
            write_en <= 1'b1;
            sum      <= sum + rx_byte;
            addr     <= addr + 1'b1;
            len      <= len - 16'd1;
            state    <= LOAD_WR;
            if (ECHO) begin
              tx_byte  <= rx_byte;
              transmit <= 1'b1;
            end
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        LOAD_WR: state <= (len == 16'd0) ? TX_RESULT : LOAD_WAIT;
        DUMP_RD: begin
          raddr <= addr;
          state <= DUMP_LAT;
        end
        DUMP_LAT: state <= DUMP_TX;
        // Returning through DUMP_RD/DUMP_LAT covers the UART's late busy flag.
        DUMP_TX: begin
          if (!is_transmitting) begin
            tx_byte  <= dout;
            transmit <= 1'b1;
            addr     <= addr + 1'b1;
            len      <= len - 16'd1;
            state    <= (len == 16'd1) ? IDLE : DUMP_RD;
          end
        end
        SUM_RD: begin
          raddr <= addr;
          addr  <= addr + 1'b1;
          state <= SUM_LAT;
        end
        SUM_LAT: state <= SUM_ACC;
        // Next read is issued while accumulating, giving two cycles per byte.
        SUM_ACC: begin
          sum <= sum + dout;
          len <= len - 16'd1;
          if (len == 16'd1) begin
            state <= TX_RESULT;
          end else begin
            raddr <= addr;
            addr  <= addr + 1'b1;
            state <= SUM_LAT;
          end
        end
        TX_RESULT: begin
          if (!is_transmitting) begin
            tx_byte  <= sum;
            transmit <= 1'b1;
            state    <= IDLE;
          end
        end
        EXEC_RST: begin
          cpu_reset <= 1'b1;
          run_armed <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (!run_armed) begin
            run_armed <= 1'b1;
          end else if (halted) begin
            monitor_control <= 1'b1;
            sum             <= REPLY_HALT;
            state           <= TX_RESULT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_monitor.sv
// Directed testbench for serial_monitor: RAM model, UART busy model and a
// byte-capture monitor; expected replies are hand-computed constants.
module tb_serial_monitor;
  localparam int AW = 12;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_byte;
  logic          received;
  logic          is_transmitting;
  logic [7:0]    tx_byte;
  logic          transmit;
  logic [AW-1:0] raddr;
  logic [7:0]    dout;
  logic [AW-1:0] waddr;
  logic [7:0]    din;
  logic          write_en;
  logic          cpu_reset;
  logic [AW-1:0] startaddr;
  logic          halted;
  logic          monitor_control;
  logic [3:0]    state_out;
  logic          timeout_err;

  serial_monitor #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100), .ECHO(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .raddr(raddr), .dout(dout), .waddr(waddr), .din(din), .write_en(write_en),
    .cpu_reset(cpu_reset), .startaddr(startaddr), .halted(halted),
    .monitor_control(monitor_control), .state_out(state_out), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    dout <= mem[raddr];
    if (write_en) mem[waddr] <= din;
  end

  // UART: busy from the cycle after a transmit strobe, for 10 cycles
  int unsigned busy_cnt = 0;
  always @(posedge clk) begin
    if (transmit) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign is_transmitting = (busy_cnt != 0);

  // Output monitor, sampled mid-cycle
  bq_t  tx_q;
  int   wr_cnt = 0, we_double = 0, busy_viol = 0, rst_pulses = 0;
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (transmit) begin
      tx_q.push_back(tx_byte);
      if (is_transmitting) busy_viol++;
    end
    if (write_en) begin
      wr_cnt++;
      if (we_prev) we_double++;
    end
    we_prev = write_en;
    if (cpu_reset) rst_pulses++;
  end

  int n_checks = 0, n_pass = 0;
  logic echo_ok;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_byte  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    echo_ok  = transmit && (tx_byte == b);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_seq(input bq_t bs);
    foreach (bs[i]) send_byte(bs[i], 20);
  endtask

  // Wait (bounded) for the expected byte count, let trailing bytes appear, compare.
  task automatic expect_tx(input string tag, input bq_t exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tx_q.size() >= exp.size()) break;
      @(negedge clk);
    end
    repeat (30) @(negedge clk);
    check({tag, "_count"}, 64'(tx_q.size()), 64'(exp.size()));
    foreach (exp[i])
      check($sformatf("%s_b%0d", tag, i),
            (i < tx_q.size()) ? 64'(tx_q[i]) : 64'hDEAD, 64'(exp[i]));
    tx_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t s, e;
    int  wr0;
    rst = 1'b1; rx_byte = '0; received = 1'b0; halted = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state_out), 64'd0);
    check("rst_mc", 64'(monitor_control), 64'd1);
    check("rst_strobes", 64'({transmit, write_en, cpu_reset, timeout_err}), 64'd0);
    check("rst_bus", 64'({tx_byte, din, raddr, waddr, startaddr}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Load three bytes at 0x010
    send_byte(8'h4C, 20);
    check("echo_timing", 64'(echo_ok), 64'd1);
    s = '{8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'h55, 8'h01}; send_seq(s);
    e = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'h55, 8'h01, 8'h00};
    expect_tx("load", e, 300);
    check("ram_010", 64'(mem[12'h010]), 64'hAA);
    check("ram_011", 64'(mem[12'h011]), 64'h55);
    check("ram_012", 64'(mem[12'h012]), 64'h01);
    check("wr_pulses", 64'(wr_cnt), 64'd3);
    check("wr_single", 64'(we_double), 64'd0);

    // Zero-length load replies 0x00 without writing
    s = '{8'h4C, 8'h00, 8'h20, 8'h00, 8'h00}; send_seq(s);
    e = '{8'h4C, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    expect_tx("load0", e, 300);
    check("load0_nowr", 64'(wr_cnt), 64'd3);

    // Dump back, respecting UART busy
    s = '{8'h44, 8'h00, 8'h10, 8'h00, 8'h03}; send_seq(s);
    e = '{8'h44, 8'h00, 8'h10, 8'h00, 8'h03, 8'hAA, 8'h55, 8'h01};
    expect_tx("dump", e, 300);
    check("dump_busy_ok", 64'(busy_viol), 64'd0);
    check("dump_idle", 64'(state_out), 64'd0);

    // Checksums: AA+55+01 = 0x00, AA+55 = 0xFF
    s = '{8'h43, 8'h00, 8'h10, 8'h00, 8'h03}; send_seq(s);
    e = '{8'h43, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00};
    expect_tx("sum3", e, 300);
    s = '{8'h43, 8'h00, 8'h10, 8'h00, 8'h02}; send_seq(s);
    e = '{8'h43, 8'h00, 8'h10, 8'h00, 8'h02, 8'hFF};
    expect_tx("sum2", e, 300);

    // Address wrap at 12 bits; reply 11+22 = 33
    s = '{8'h4C, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22}; send_seq(s);
    e = '{8'h4C, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    expect_tx("wrap_load", e, 300);
    check("ram_fff", 64'(mem[12'hFFF]), 64'h11);
    check("ram_000", 64'(mem[12'h000]), 64'h22);
    s = '{8'h44, 8'h0F, 8'hFF, 8'h00, 8'h02}; send_seq(s);
    e = '{8'h44, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22};
    expect_tx("wrap_dump", e, 300);

    // Exec at 0x100, halt after 50 cycles
    rst_pulses = 0;
    s = '{8'h58, 8'h01, 8'h00, 8'h00, 8'h00}; send_seq(s);
    e = '{8'h58, 8'h01, 8'h00, 8'h00, 8'h00};
    expect_tx("exec_hdr", e, 300);
    check("exec_start", 64'(startaddr), 64'h100);
    check("exec_mc", 64'(monitor_control), 64'd0);
    check("exec_rst_len", 64'(rst_pulses), 64'd2);
    check("exec_run", 64'(state_out), 64'd13);
    repeat (50) @(negedge clk);
    halted = 1'b1;
    e = '{8'h48};
    expect_tx("halt", e, 300);
    check("halt_mc", 64'(monitor_control), 64'd1);
    check("halt_idle", 64'(state_out), 64'd0);
    halted = 1'b0;

    // Timeout mid-header
    wr0 = wr_cnt;
    send_byte(8'h4C, 20);
    send_byte(8'h00, 20);
    repeat (60) @(negedge clk);
    check("tmo_pending", 64'(state_out), 64'd1);
    repeat (40) @(negedge clk);
    check("tmo_idle", 64'(state_out), 64'd0);
    check("tmo_err", 64'(timeout_err), 64'd1);
    check("tmo_nowr", 64'(wr_cnt), 64'(wr0));
    e = '{8'h4C, 8'h00};
    expect_tx("tmo_echo", e, 10);
    send_byte(8'h44, 20);
    check("tmo_clear", 64'(timeout_err), 64'd0);
    check("tmo_hdr", 64'(state_out), 64'd1);
    repeat (120) @(negedge clk);
    check("tmo_again", 64'(timeout_err), 64'd1);
    tx_q.delete();

    // Unknown command
    send_byte(8'h7E, 0);
    e = '{8'h3F};
    expect_tx("unknown", e, 50);
    check("unknown_idle", 64'(state_out), 64'd0);
    check("unknown_keeps_err", 64'(timeout_err), 64'd1);

    // Reset in the middle of a dump
    s = '{8'h44, 8'h00, 8'h10, 8'h00}; send_seq(s);
    send_byte(8'h03, 0);
    for (int i = 0; i < 100; i++) begin
      if (tx_q.size() >= 6) break;
      @(negedge clk);
    end
    check("mid_dump_started", 64'(tx_q.size() >= 6), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 64'(state_out), 64'd0);
    check("mid_rst_mc", 64'(monitor_control), 64'd1);
    check("mid_rst_strobes", 64'({transmit, write_en, cpu_reset, timeout_err}), 64'd0);
    check("mid_rst_bus", 64'({tx_byte, din, raddr, waddr, startaddr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    repeat (100) @(negedge clk);
    check("mid_rst_silent", 64'(tx_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
